// File: rtl/vdp_result_stage.sv
// Per-vector result stage for the vdp datapath: turns the free-running MAC accumulator
// into one saturated dot product per K valid elements, held in a single-entry output register.
module vdp_result_stage #(
  parameter int N     = 8,
  parameter int K     = 3,
  parameter int L     = 2*(N-1)+K,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [L-1:0]     acc,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sat,
  output logic [7:0]              out_idx,
  output logic                    overrun
);

  // Handshake: a result transfers on a rising edge where out_valid && out_ready; out_valid
  // stays high and out_data/out_sat/out_idx stay stable until that transfer happens.

  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K-1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic signed [L-1:0] acc_q, base, b_sel, diff;
  logic [L-OUT_W:0]    top;
  logic                ovf, complete, load;
  logic [OUT_W-1:0]    sat_data;
  logic [7:0]          vec_no;

  // The element counter doubles as the state register; the enum names its two regions.
  assign state    = (cnt == '0) ? IDLE : ACC;
  assign complete = in_valid && (cnt == LAST);
  assign load     = complete && (!out_valid || out_ready);

  always_comb begin
    cnt_nxt = cnt;
    if (in_valid) begin
      if (complete) cnt_nxt = '0;
      else          cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // With K==1 the base register is only written on the same edge it would be read,
  // so the pre-vector accumulator comes straight from acc_q.
  assign b_sel = (K == 1) ? acc_q : base;
  assign diff  = acc - b_sel;

  // Result fits when every bit from the OUT_W sign position upward agrees.
  assign top = diff[L-1:OUT_W-1];
  assign ovf = !((&top) || !(|top));

  always_comb begin
    sat_data = diff[OUT_W-1:0];
    if (ovf) sat_data = diff[L-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      base      <= '0;
      cnt       <= '0;
      vec_no    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      out_idx   <= '0;
      overrun   <= 1'b0;
    end else begin
      acc_q <= acc;
      cnt   <= cnt_nxt;
      if (state == IDLE && in_valid) base <= acc_q;
      if (complete) vec_no <= vec_no + 8'd1;
      if (load) begin
        out_data  <= sat_data;
        out_sat   <= ovf;
        out_idx   <= vec_no;
        out_valid <= 1'b1;
      end else if (complete) begin
        overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vdp_result_stage.sv
// Bench for vdp_result_stage: a behavioural MAC drives acc, a sum-of-products model
// predicts each vector's result, and a monitor checks every presented output.
module tb_vdp_result_stage;

  localparam int N     = 8;
  localparam int K     = 3;
  localparam int L     = 2*(N-1)+K;
  localparam int OUT_W = 16;
  localparam int EW    = OUT_W + 9;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic signed [L-1:0] acc;
  logic [OUT_W-1:0]    out_data;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic                out_sat;
  logic [7:0]          out_idx;
  logic                overrun;

  int checks = 0;
  int errors = 0;

  // Behavioural MAC: o = o_reg + a*b, o_reg shares the stage's reset.
  int                  pa = 0, pb = 0;
  logic signed [L-1:0] mac_reg;
  logic                preload_en = 1'b0;
  logic signed [L-1:0] preload_val = '0;

  assign acc = mac_reg + (in_valid ? L'(pa * pb) : L'(0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             mac_reg <= '0;
    else if (preload_en) mac_reg <= preload_val;
    else                 mac_reg <= acc;
  end

  always #5 clk = ~clk;

  vdp_result_stage #(.N(N), .K(K), .L(L), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .acc(acc),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sat(out_sat), .out_idx(out_idx), .overrun(overrun)
  );

  // Reference model state
  logic [EW-1:0] exp_q[$];
  int   sum_m = 0, cnt_m = 0, vec_m = 0;
  logic full_m = 1'b0, ovr_m = 1'b0;

  function automatic logic [EW-1:0] mk(input int s, input int idx);
    int   mx = (1 << (OUT_W-1)) - 1;
    int   mn = -(1 << (OUT_W-1));
    int   v = s;
    logic sat = 1'b0;
    if (s > mx) begin v = mx; sat = 1'b1; end
    if (s < mn) begin v = mn; sat = 1'b1; end
    return {sat, 8'(idx), OUT_W'(v)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // One cycle of stimulus; the model predicts what the following clock edge does.
  task automatic step(input logic v, input int a, input int b, input logic rdy);
    logic done;
    @(posedge clk); #1;
    preload_en = 1'b0;
    in_valid = v; pa = a; pb = b; out_ready = rdy;
    done = 1'b0;
    if (v) begin
      sum_m += a * b;
      cnt_m++;
      if (cnt_m == K) begin done = 1'b1; cnt_m = 0; end
    end
    if (done) begin
      if (!full_m || rdy) begin exp_q.push_back(mk(sum_m, vec_m)); full_m = 1'b1; end
      else ovr_m = 1'b1;
      vec_m = (vec_m + 1) % 256;
      sum_m = 0;
    end else if (full_m && rdy) begin
      full_m = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; preload_en = 1'b0;
    sum_m = 0; cnt_m = 0; vec_m = 0; full_m = 1'b0; ovr_m = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_sat",   32'(out_sat),   32'd0);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: the presented output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=%0h expected=none", {out_sat, out_idx, out_data});
      end else begin
        if ({out_sat, out_idx, out_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL result actual=%0h expected=%0h", {out_sat, out_idx, out_data}, exp_q[0]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    do_reset();

    // Basic vector, then saturating follow-on vector
    step(1, 2, 3, 1); step(1, -4, 5, 1); step(1, 7, 7, 1);
    for (int i = 0; i < 3; i++) step(1, -128, -128, 1);
    step(0, 0, 0, 1);

    // Accumulator wrap-around from a large base
    step(0, 0, 0, 1);
    preload_en = 1'b1; preload_val = L'(65000);
    step(0, 0, 0, 1);
    step(1, -128, -128, 1); step(1, 1, 1, 1); step(1, 1, 1, 1);
    step(0, 0, 0, 1);

    // Idle gaps between elements
    step(1, 2, 3, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    step(1, -4, 5, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    step(1, 7, 7, 1); step(0, 0, 0, 1);

    // Backpressure: second result dropped, overrun sticks
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 3, 4, 0);
    for (int i = 0; i < 3; i++) step(1, -5, 6, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    check("bp_overrun", 32'(overrun), 32'(ovr_m));
    check("bp_idx_held", 32'(out_idx), 32'd0);
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    @(negedge clk);
    check("bp_valid_fell", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 1, 2, 1);
    step(0, 0, 0, 1);

    // Reset mid-vector
    step(1, 9, 9, 1); step(1, 9, 9, 1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1);
    step(0, 0, 0, 1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128, $urandom_range(0, 3) != 0);
    end

    // Drain
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    @(negedge clk);
    check("final_overrun", 32'(overrun), 32'(ovr_m));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
